// File: rtl/mmc3_bus_ctrl_pkg.sv
// Shared MMC3 definitions: CPU register indices, save-state offsets and reset values.
package mmc3_pkg;

    localparam logic [3:0] REG_BSEL       = 4'h8;
    localparam logic [3:0] REG_BDATA      = 4'h9;
    localparam logic [3:0] REG_MIRROR     = 4'hA;
    localparam logic [3:0] REG_WRAM       = 4'hB;
    localparam logic [3:0] REG_IRQ_LATCH  = 4'hC;
    localparam logic [3:0] REG_IRQ_RELOAD = 4'hD;
    localparam logic [3:0] REG_IRQ_DIS    = 4'hE;
    localparam logic [3:0] REG_IRQ_EN     = 4'hF;

    localparam logic [3:0] SST_OFF_BSEL   = 4'd8;
    localparam logic [3:0] SST_OFF_MIRROR = 4'd9;
    localparam logic [3:0] SST_OFF_WRAM   = 4'd10;
    localparam int         SST_SPAN       = 11;

    localparam logic [63:0] BANK_R_RST = 64'h0706050403020100;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SST = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mmc3_bus_ctrl_if.sv
// CPU bus into the mapper plus the decoded register-write strobe out of it.
interface mmc3_bus_ctrl_if;
    logic        cpu_m2;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        decode_en;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_data;

    modport master (output cpu_m2, cpu_rw, cpu_addr, cpu_data,
                    input  decode_en, reg_addr, reg_data);
    modport slave  (input  cpu_m2, cpu_rw, cpu_addr, cpu_data,
                    output decode_en, reg_addr, reg_data);
endinterface

// File: rtl/mmc3_bus_ctrl_m2_qual.sv
// M2 synchroniser and high-phase qualifier; flags a falling edge that ended a long-enough high phase.
module m2_qual #(
    parameter int M2_MIN_HI = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic m2_raw,
    output logic m2_hi,
    output logic fall_ok
);
    localparam int CNT_W = $clog2(M2_MIN_HI + 2);

    logic [2:0]       m2_st;
    logic [CNT_W-1:0] hi_cnt_reg;
    logic             armed_reg;

    always_ff @(posedge clk) begin
        m2_st <= {m2_st[1:0], m2_raw};
    end

    // armed_reg only sets on a low sample, so a high phase already in progress when clr drops never qualifies
    always_ff @(posedge clk) begin
        if (clr) begin
            hi_cnt_reg <= '0;
            armed_reg  <= 1'b0;
        end else if (m2_st[1]) begin
            if (hi_cnt_reg != '1)
                hi_cnt_reg <= hi_cnt_reg + 1'b1;
        end else begin
            hi_cnt_reg <= '0;
            armed_reg  <= 1'b1;
        end
    end

    assign m2_hi   = m2_st[1];
    assign fall_ok = (m2_st[2:1] == 2'b10) && armed_reg &&
                     (hi_cnt_reg >= CNT_W'(M2_MIN_HI));
endmodule

// File: rtl/mmc3_bus_ctrl.sv
// MMC3 CPU register front end: qualified write strobes, bank/mirror/WRAM registers, save-state access.
module mmc3_bus_ctrl
    import mmc3_pkg::*;
#(
    parameter int M2_MIN_HI = 2,
    parameter int SST_BASE  = 0
) (
    input  logic            clk,
    input  logic            map_rst,
    mmc3_bus_ctrl_if.slave  bus,
    input  logic            sst_act,
    input  logic            sst_we_reg,
    input  logic [7:0]      sst_addr,
    input  logic [7:0]      sst_dato,
    output logic [2:0]      bank_sel,
    output logic            prg_mode,
    output logic            chr_mode,
    output logic [63:0]     bank_r,
    output logic            mirror_h,
    output logic            ram_en,
    output logic            ram_wp,
    output logic            sst_ce,
    output logic [7:0]      sst_do
);
    bus_state_t state_reg, state_next;
    logic       sst_hold;
    logic       m2_hi, fall_ok, wr_fire;
    logic [3:0] cap_a_reg;
    logic       cap_rw_reg;
    logic [7:0] cap_data_reg;
    logic [3:0] wr_idx;
    logic       decode_en_reg;
    logic [3:0] reg_addr_reg;
    logic [7:0] reg_data_reg;
    logic [2:0] bank_sel_reg;
    logic       prg_mode_reg, chr_mode_reg, mirror_h_reg, ram_en_reg, ram_wp_reg;
    logic [8:0] sst_off9;
    logic [3:0] sst_off;
    logic       sst_hit, sst_wr;

    always_ff @(posedge clk) begin
        if (map_rst) state_reg <= ST_RUN;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        sst_hold   = sst_act;
        case (state_reg)
            ST_RUN: if (sst_act) state_next = ST_SST;
            ST_SST: begin
                sst_hold = 1'b1;
                if (!sst_act) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    m2_qual #(.M2_MIN_HI(M2_MIN_HI)) u_m2_qual (
        .clk     (clk),
        .clr     (map_rst | sst_hold),
        .m2_raw  (bus.cpu_m2),
        .m2_hi   (m2_hi),
        .fall_ok (fall_ok)
    );

    // Only A15, A14, A13 and A0 matter for MMC3 register decode
    always_ff @(posedge clk) begin
        if (map_rst) begin
            cap_a_reg    <= '0;
            cap_rw_reg   <= 1'b1;
            cap_data_reg <= '0;
        end else if (m2_hi && !sst_hold) begin
            cap_a_reg    <= {bus.cpu_addr[15:13], bus.cpu_addr[0]};
            cap_rw_reg   <= bus.cpu_rw;
            cap_data_reg <= bus.cpu_data;
        end
    end

    assign wr_fire = fall_ok && !cap_rw_reg && cap_a_reg[3] && !sst_hold && !map_rst;
    assign wr_idx  = {1'b1, cap_a_reg[2:0]};

    always_ff @(posedge clk) begin
        if (map_rst) begin
            decode_en_reg <= 1'b0;
            reg_addr_reg  <= '0;
            reg_data_reg  <= '0;
        end else begin
            decode_en_reg <= wr_fire;
            if (wr_fire) begin
                reg_addr_reg <= wr_idx;
                reg_data_reg <= cap_data_reg;
            end
        end
    end

    assign sst_off9 = {1'b0, sst_addr} - 9'(SST_BASE);
    assign sst_hit  = ({1'b0, sst_addr} >= 9'(SST_BASE)) && (sst_off9 < 9'(SST_SPAN));
    assign sst_off  = sst_off9[3:0];
    assign sst_wr   = sst_act && sst_we_reg && sst_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bank
            logic [7:0] r_reg;
            always_ff @(posedge clk) begin
                if (sst_wr && sst_off == 4'(gi))
                    r_reg <= sst_dato;
                else if (map_rst)
                    r_reg <= BANK_R_RST[gi*8 +: 8];
                else if (wr_fire && wr_idx == REG_BDATA && bank_sel_reg == 3'(gi))
                    r_reg <= cap_data_reg;
            end
            assign bank_r[gi*8 +: 8] = r_reg;
        end
    endgenerate

    // Save-state writes win over reset so a restore issued alongside map_rst is not lost
    always_ff @(posedge clk) begin
        if (sst_wr && sst_off == SST_OFF_BSEL) begin
            chr_mode_reg <= sst_dato[7];
            prg_mode_reg <= sst_dato[6];
            bank_sel_reg <= sst_dato[2:0];
        end else if (map_rst) begin
            chr_mode_reg <= 1'b0;
            prg_mode_reg <= 1'b0;
            bank_sel_reg <= '0;
        end else if (wr_fire && wr_idx == REG_BSEL) begin
            chr_mode_reg <= cap_data_reg[7];
            prg_mode_reg <= cap_data_reg[6];
            bank_sel_reg <= cap_data_reg[2:0];
        end

        if (sst_wr && sst_off == SST_OFF_MIRROR)
            mirror_h_reg <= sst_dato[0];
        else if (map_rst)
            mirror_h_reg <= 1'b0;
        else if (wr_fire && wr_idx == REG_MIRROR)
            mirror_h_reg <= cap_data_reg[0];

        if (sst_wr && sst_off == SST_OFF_WRAM) begin
            ram_en_reg <= sst_dato[7];
            ram_wp_reg <= sst_dato[6];
        end else if (map_rst) begin
            ram_en_reg <= 1'b0;
            ram_wp_reg <= 1'b0;
        end else if (wr_fire && wr_idx == REG_WRAM) begin
            ram_en_reg <= cap_data_reg[7];
            ram_wp_reg <= cap_data_reg[6];
        end
    end

    always_comb begin
        sst_do = 8'hFF;
        if (sst_hit) begin
            if (sst_off < 4'd8)
                sst_do = bank_r[{sst_off[2:0], 3'b000} +: 8];
            else if (sst_off == SST_OFF_BSEL)
                sst_do = {chr_mode_reg, prg_mode_reg, 3'b000, bank_sel_reg};
            else if (sst_off == SST_OFF_MIRROR)
                sst_do = {7'b0, mirror_h_reg};
            else if (sst_off == SST_OFF_WRAM)
                sst_do = {ram_en_reg, ram_wp_reg, 6'b0};
        end
    end

    assign sst_ce        = sst_hit;
    assign bus.decode_en = decode_en_reg;
    assign bus.reg_addr  = reg_addr_reg;
    assign bus.reg_data  = reg_data_reg;
    assign bank_sel      = bank_sel_reg;
    assign prg_mode      = prg_mode_reg;
    assign chr_mode      = chr_mode_reg;
    assign mirror_h      = mirror_h_reg;
    assign ram_en        = ram_en_reg;
    assign ram_wp        = ram_wp_reg;
endmodule

// File: tb/tb_mmc3_bus_ctrl.sv
// Scoreboard bench for mmc3_bus_ctrl: directed CPU and save-state vectors with hand-computed expectations.
module tb_mmc3_bus_ctrl;
    logic        clk = 1'b0;
    logic        map_rst = 1'b1;
    logic        sst_act = 1'b0, sst_we_reg = 1'b0;
    logic [7:0]  sst_addr = 8'h00, sst_dato = 8'h00;
    logic [2:0]  bank_sel;
    logic        prg_mode, chr_mode, mirror_h, ram_en, ram_wp, sst_ce;
    logic [63:0] bank_r;
    logic [7:0]  sst_do;
    int          cyc = 0;
    int          checks = 0, errors = 0;

    localparam logic [63:0] BR_RST = 64'h0706050403020100;
    localparam logic [63:0] BR_R5  = 64'h07063C0403020100;
    localparam logic [63:0] BR_R3  = 64'h070605049A020100;

    mmc3_bus_ctrl_if bus ();

    mmc3_bus_ctrl #(.M2_MIN_HI(2), .SST_BASE(0)) dut (
        .clk(clk), .map_rst(map_rst), .bus(bus),
        .sst_act(sst_act), .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
        .bank_sel(bank_sel), .prg_mode(prg_mode), .chr_mode(chr_mode), .bank_r(bank_r),
        .mirror_h(mirror_h), .ram_en(ram_en), .ram_wp(ram_wp),
        .sst_ce(sst_ce), .sst_do(sst_do)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  ra;
        logic [7:0]  rd;
        logic [2:0]  bs;
        logic        prg, chr;
        logic [63:0] br;
        logic        mh, re, wp;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(logic [3:0] ra, logic [7:0] rd, logic [2:0] bs, logic prg,
                                logic chr, logic [63:0] br, logic mh, logic re, logic wp);
        exp_t e;
        e.cyc = 0; e.ra = ra; e.rd = rd; e.bs = bs; e.prg = prg; e.chr = chr;
        e.br = br; e.mh = mh; e.re = re; e.wp = wp;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                             input int hi, input bit strobe, input exp_t e);
        exp_t x;
        x = e;
        bus.cpu_addr = a; bus.cpu_rw = rw; bus.cpu_data = d; bus.cpu_m2 = 1'b1;
        tick(hi);
        bus.cpu_m2 = 1'b0;
        if (strobe) begin
            x.cyc = cyc + 3;
            q.push_back(x);
        end
        $display("cpu %s addr=%h data=%h hi=%0d strobe_expected=%0d",
                 rw ? "rd" : "wr", a, d, hi, strobe);
        tick(4);
        bus.cpu_rw = 1'b1;
        tick(3);
    endtask

    // Monitor: every strobe must match the head of the queue, at its expected cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && cyc > q[0].cyc) begin
                checks++; errors++;
                $display("FAIL missing_strobe: got none expected reg_addr=%h at cycle %0d", q[0].ra, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.decode_en === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got reg_addr=%h reg_data=%h expected none (cycle %0d)",
                             bus.reg_addr, bus.reg_data, cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    chk("reg_addr", 64'(bus.reg_addr), 64'(e.ra));
                    chk("reg_data", 64'(bus.reg_data), 64'(e.rd));
                    chk("bank_sel", 64'(bank_sel), 64'(e.bs));
                    chk("prg_mode", 64'(prg_mode), 64'(e.prg));
                    chk("chr_mode", 64'(chr_mode), 64'(e.chr));
                    chk("bank_r", bank_r, e.br);
                    chk("mirror_h", 64'(mirror_h), 64'(e.mh));
                    chk("ram_en", 64'(ram_en), 64'(e.re));
                    chk("ram_wp", 64'(ram_wp), 64'(e.wp));
                    $display("strobe reg_addr=%h reg_data=%h cycle %0d", bus.reg_addr, bus.reg_data, cyc);
                end
            end
        end
    end

    initial begin
        exp_t none;
        int   wait_n;
        none = mk(4'h0, 8'h00, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        bus.cpu_m2 = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h0000; bus.cpu_data = 8'h00;

        tick(3);
        map_rst = 1'b0;
        sst_addr = 8'd3;
        tick(1);
        chk("rst_decode_en", 64'(bus.decode_en), 64'd0);
        chk("rst_reg_addr", 64'(bus.reg_addr), 64'd0);
        chk("rst_reg_data", 64'(bus.reg_data), 64'd0);
        chk("rst_bank_sel", 64'(bank_sel), 64'd0);
        chk("rst_bank_r", bank_r, BR_RST);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_sst_do3", 64'(sst_do), 64'h03);
        chk("rst_sst_ce", 64'(sst_ce), 64'd1);
        $display("reset done");

        cpu_cycle(16'h8000, 1'b0, 8'hC5, 6, 1'b1, mk(4'h8, 8'hC5, 3'd5, 1'b1, 1'b1, BR_RST, 1'b0, 1'b0, 1'b0));
        cpu_cycle(16'h8001, 1'b0, 8'h3C, 6, 1'b1, mk(4'h9, 8'h3C, 3'd5, 1'b1, 1'b1, BR_R5, 1'b0, 1'b0, 1'b0));
        cpu_cycle(16'hE001, 1'b0, 8'hA5, 6, 1'b1, mk(4'hF, 8'hA5, 3'd5, 1'b1, 1'b1, BR_R5, 1'b0, 1'b0, 1'b0));
        cpu_cycle(16'hA000, 1'b0, 8'h01, 3, 1'b1, mk(4'hA, 8'h01, 3'd5, 1'b1, 1'b1, BR_R5, 1'b1, 1'b0, 1'b0));
        cpu_cycle(16'hA001, 1'b0, 8'hC0, 6, 1'b1, mk(4'hB, 8'hC0, 3'd5, 1'b1, 1'b1, BR_R5, 1'b1, 1'b1, 1'b1));
        cpu_cycle(16'hC000, 1'b0, 8'h55, 1, 1'b0, none);
        cpu_cycle(16'hC001, 1'b1, 8'h55, 6, 1'b0, none);
        cpu_cycle(16'h7FFF, 1'b0, 8'h55, 6, 1'b0, none);

        // map_rst in the middle of a $A001 write high phase
        bus.cpu_addr = 16'hA001; bus.cpu_rw = 1'b0; bus.cpu_data = 8'h80; bus.cpu_m2 = 1'b1;
        tick(3);
        map_rst = 1'b1;
        tick(1);
        map_rst = 1'b0;
        tick(3);
        bus.cpu_m2 = 1'b0;
        tick(6);
        bus.cpu_rw = 1'b1;
        chk("mrst_ram_en", 64'(ram_en), 64'd0);
        chk("mrst_mirror_h", 64'(mirror_h), 64'd0);
        chk("mrst_bank_r", bank_r, BR_RST);
        chk("mrst_reg_addr", 64'(bus.reg_addr), 64'd0);
        $display("map_rst mid-write done");

        // Save-state restore with a concurrent CPU write that must be ignored
        sst_act = 1'b1;
        tick(1);
        sst_we_reg = 1'b1; sst_addr = 8'd8; sst_dato = 8'h46;
        tick(1);
        sst_addr = 8'd3; sst_dato = 8'h9A;
        tick(1);
        sst_we_reg = 1'b0;
        cpu_cycle(16'h8000, 1'b0, 8'h07, 6, 1'b0, none);
        chk("sst_bank_sel", 64'(bank_sel), 64'd6);
        chk("sst_prg_mode", 64'(prg_mode), 64'd1);
        chk("sst_chr_mode", 64'(chr_mode), 64'd0);
        chk("sst_bank_r", bank_r, BR_R3);
        sst_addr = 8'd8;  #1 chk("sst_rd8", 64'(sst_do), 64'h46);
        sst_addr = 8'd3;  #1 chk("sst_rd3", 64'(sst_do), 64'h9A);
        sst_addr = 8'd10; #1 chk("sst_rd10", 64'(sst_do), 64'h00);
        sst_addr = 8'd11; #1 chk("sst_rd11", 64'(sst_do), 64'hFF);
        chk("sst_ce11", 64'(sst_ce), 64'd0);
        $display("sst restore done");

        // sst_act drops mid high phase: that cycle is dropped, the next one strobes
        bus.cpu_addr = 16'hA000; bus.cpu_rw = 1'b0; bus.cpu_data = 8'h01; bus.cpu_m2 = 1'b1;
        tick(2);
        sst_act = 1'b0;
        tick(5);
        bus.cpu_m2 = 1'b0;
        tick(6);
        bus.cpu_rw = 1'b1;
        tick(2);
        cpu_cycle(16'hA000, 1'b0, 8'h01, 6, 1'b1, mk(4'hA, 8'h01, 3'd6, 1'b1, 1'b0, BR_R3, 1'b1, 1'b0, 1'b0));

        wait_n = 0;
        while (q.size() != 0 && wait_n < 50) begin
            tick(1);
            wait_n++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmc3_bus_ctrl.md
Name: mmc3_bus_ctrl

Overview:
- CPU-side register front end for the MMC3 mapper.
- Synchronises M2, qualifies CPU writes to $8000-$FFFF and emits one-clock `decode_en`/`reg_addr`/`reg_data` strobes.
- These strobes sequence the scanline IRQ counter block and all other MMC3 register consumers.
- Holds the bank-select, bank, mirroring and WRAM-control registers, and serves them to save-state (SST) readback and restore.

Parameters:
- M2_MIN_HI, 2: minimum consecutive clk samples of synchronised M2 high before a falling edge is accepted as a bus cycle.
- SST_BASE, 0: SST register base address; this block occupies SST_BASE..SST_BASE+10.

Ports:
- clk  in  1  system clock
- map_rst  in  1  synchronous active-high reset
- cpu_m2  in  1  raw CPU M2
- cpu_rw  in  1  CPU R/W (0 = write)
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU data bus
- sst_act  in  1  save-state engine active
- sst_we_reg  in  1  SST register write strobe
- sst_addr  in  8  SST register address
- sst_dato  in  8  SST write data
- decode_en  out  1  one-clk register write strobe
- reg_addr  out  4  {1, A14, A13, A0}; valid with decode_en
- reg_data  out  8  latched write data; valid with decode_en
- bank_sel  out  3  $8000 bits[2:0]
- prg_mode  out  1  $8000 bit6
- chr_mode  out  1  $8000 bit7
- bank_r  out  64  R0..R7, 8 bits each, R0 in [7:0]
- mirror_h  out  1  $A000 bit0
- ram_en  out  1  $A001 bit7
- ram_wp  out  1  $A001 bit6
- sst_ce  out  1  SST address hits this block
- sst_do  out  8  SST readback data

Behaviour:
- M2 sync: 3-stage shift register `m2_st` on posedge clk. Falling edge = `m2_st[2:1]` == 2'b10.
- hi_cnt: saturating counter, cleared while synchronised M2 is low, incremented while high.
- Accepted edge: falling edge with hi_cnt >= M2_MIN_HI.
- Capture: cpu_addr, cpu_rw and cpu_data are registered every clk while synchronised M2 is high. The last high-phase sample is the one used.
- Write qualification: accepted edge AND captured rw == 0 AND captured A15 == 1.
- On qualification, the next clk:
  - decode_en = 1 for exactly one clk.
  - reg_addr = {1, A14, A13, A0}.
  - reg_data = captured data.
- Latency: decode_en asserts 2 clk after M2 is sampled low at stage 0.
- reg_addr/reg_data hold their last value between strobes.
- At most one decode_en per M2 high phase. A glitch shorter than M2_MIN_HI produces none.
- Internal register file, updated in the same clk that decode_en asserts:
  - 8: bank_sel, prg_mode, chr_mode from data bits [2:0], 6, 7.
  - 9: bank_r[bank_sel] = data.
  - A: mirror_h = data[0].
  - B: ram_en = data[7], ram_wp = data[6].
  - C..F: strobe only; no local state.
- States:
  - RUN: normal operation.
  - SST: entered when sst_act = 1.
    - decode_en forced 0, and CPU captures are discarded.
    - hi_cnt is cleared so a partial bus cycle is never replayed.
    - Returns to RUN the clk after sst_act falls.
    - The first strobe after return requires a fresh full M2 high phase.
- SST map, offset from SST_BASE:
  - 0..7: R0..R7.
  - 8: {chr_mode, prg_mode, 3'b0, bank_sel}.
  - 9: {7'b0, mirror_h}.
  - 10: {ram_en, ram_wp, 6'b0}.
- SST timing:
  - sst_ce is combinational on sst_addr; sst_do = 8'hFF outside the range.
  - SST writes (sst_act & sst_we_reg & hit) load the registers the same clk.
  - SST writes take priority over map_rst.
- map_rst, synchronous, outside SST:
  - decode_en = 0, reg_addr = 0, reg_data = 0, hi_cnt = 0.
  - bank_sel = 0, prg_mode = 0, chr_mode = 0, mirror_h = 0, ram_en = 0, ram_wp = 0.
  - bank_r = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00}.
  - A pending edge during reset is dropped.
- Reads (rw = 1) and $0000-$7FFF writes never strobe.

Decomposition:
- Shared package mmc3_pkg:
  - Register index constants REG_BSEL = 4'h8 .. REG_IRQ_EN = 4'hF.
  - SST offset constants.
  - Reset value of bank_r.
- One sub-module, m2_qual: synchroniser, hi_cnt and accepted-edge output, reused by other mappers.
- Register file and SST mux stay in the top.

Test Plan:
- Write $8000 = 8'hC5 (M2 high 6 clk) -> one decode_en, reg_addr = 4'h8, bank_sel = 5, prg_mode = 1, chr_mode = 1, 2 clk after M2 falls.
- After that, write $8001 = 8'h3C -> bank_r[47:40] = 8'h3C; then write $E001 -> decode_en, reg_addr = 4'hF, reg_data = CPU value, registers unchanged.
- M2 glitch high 1 clk with rw = 0, A = $C000 -> no decode_en. Read of $C001 with M2 high 6 clk -> no decode_en.
- Assert map_rst mid-M2-high during a $A001 write -> no strobe, ram_en = 0, bank_r = reset pattern.
- SST write offset 8 = 8'h46, offset 3 = 8'h9A while sst_act -> bank_sel = 6, prg_mode = 1, R3 = 8'h9A; readback matches; sst_do = 8'hFF at offset 11. A concurrent CPU write is suppressed.
- sst_act falls mid M2 high -> no strobe for that cycle; the next full cycle strobes normally.
